hazard_unit: RTL and testbench

Pipeline hazard controller: the producer of the stall and flush controls consumed by the PC register, the IF/ID register and the ID/EX register. It detects load-use hazards between the instruction in ID and a load in EX, and branch mispredictions resolved in EX. It holds the stall or flush for a configurable number of cycles using a small counter-driven FSM. Optional performance counters record stall cycles and flush events.

---
 rtl/hazard_unit.sv | 159 +++++++++++++++
 tb/tb_hazard_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the PC, IF/ID and ID/EX registers.
// Detects load-use hazards (ID vs. load in EX) and EX-resolved branch
// mispredictions, and holds the stall or flush for a parameterised number
// of cycles with a small counter-driven FSM. Control outputs are Mealy.
//
// Parameters:
//   LOAD_LATENCY  total stall cycles per load-use hazard (1..15)
//   FLUSH_CYCLES  total flush cycles per misprediction (1..15)
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   id_rs1/rs2_addr_i    source register indices of the ID instruction
//   id_rs1/rs2_use_i     ID instruction actually reads rs1 / rs2
//   ex_reg_wr_addr_i     destination register of the EX instruction
//   ex_reg_wr_sig_i      EX instruction writes the register file
//   ex_is_load_i         EX instruction is a load
//   ex_br_mispred_i      EX branch/jump resolved against its prediction
//   pc_stall_o           hold PC
//   if_id_stall_o        hold IF/ID
//   if_id_flush_o        clear IF/ID to NOP
//   id_ex_bubble_o       insert bubble into ID/EX
//   stall_cnt_o          stall-cycle performance counter
//   flush_cnt_o          misprediction performance counter
// Build option:
//   HAZARD_PERF_CNT_EN   when defined, builds the two performance counters;
//                        otherwise stall_cnt_o / flush_cnt_o are tied to 0.
module hazard_unit #(
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_use_i,
  input  logic        id_rs2_use_i,
  input  logic [4:0]  ex_reg_wr_addr_i,
  input  logic        ex_reg_wr_sig_i,
  input  logic        ex_is_load_i,
  input  logic        ex_br_mispred_i,
  output logic        pc_stall_o,
  output logic        if_id_stall_o,
  output logic        if_id_flush_o,
  output logic        id_ex_bubble_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PERF_W = 32;

  // First cycle is spent in RUN, so the hold states cover the remainder.
  localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_LATENCY - 1);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic             STALL_MULTI  = (LOAD_LATENCY > 1);
  localparam logic             FLUSH_MULTI  = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use_c;
  logic             stall_c;
  logic             flush_c;

  // x0 never carries a hazard.
  assign load_use_c = ex_is_load_i & ex_reg_wr_sig_i & (ex_reg_wr_addr_i != 5'd0) &
                      ((id_rs1_use_i & (id_rs1_addr_i == ex_reg_wr_addr_i)) |
                       (id_rs2_use_i & (id_rs2_addr_i == ex_reg_wr_addr_i)));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a mispredict always wins and (re)starts the flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ex_br_mispred_i) begin
      state_d = FLUSH_MULTI ? ST_FLUSH : ST_RUN;
      cnt_d   = FLUSH_RELOAD;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (load_use_c && STALL_MULTI) begin
            state_d = ST_STALL;
            cnt_d   = STALL_RELOAD;
          end
        end
        ST_STALL, ST_FLUSH: begin
          if (cnt_q <= 4'd1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic; flush masks stall, and reset masks everything.
  always_comb begin
    flush_c = 1'b0;
    stall_c = 1'b0;
    if (!reset) begin
      flush_c = ex_br_mispred_i | (state_q == ST_FLUSH);
      stall_c = !flush_c & ((state_q == ST_STALL) | ((state_q == ST_RUN) & load_use_c));
    end
  end

  assign pc_stall_o     = stall_c;
  assign if_id_stall_o  = stall_c;
  assign if_id_flush_o  = flush_c;
  assign id_ex_bubble_o = stall_c | flush_c;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  // Free-running wrap-around performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q + PERF_W'(stall_c);
    flush_cnt_d = flush_cnt_q + PERF_W'(ex_br_mispred_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Read as zero for the whole reset window, including its first cycle.
  assign stall_cnt_o = reset ? '0 : stall_cnt_q;
  assign flush_cnt_o = reset ? '0 : flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: three instances with different latencies share
// one stimulus stream; a remaining-cycles model predicts every output.
module tb_hazard_unit;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1, rs2, wr_addr;
  logic       rs1_use, rs2_use, wr_sig, is_load, mispred;

  logic        pc_stall [NI];
  logic        ifid_stall [NI];
  logic        ifid_flush [NI];
  logic        bubble [NI];
  logic [31:0] scnt [NI];
  logic [31:0] fcnt [NI];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_unit #(.LOAD_LATENCY(1), .FLUSH_CYCLES(1)) u0 (
    .clk(clk), .reset(reset),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_use_i(rs1_use), .id_rs2_use_i(rs2_use),
    .ex_reg_wr_addr_i(wr_addr), .ex_reg_wr_sig_i(wr_sig), .ex_is_load_i(is_load),
    .ex_br_mispred_i(mispred),
    .pc_stall_o(pc_stall[0]), .if_id_stall_o(ifid_stall[0]), .if_id_flush_o(ifid_flush[0]),
    .id_ex_bubble_o(bubble[0]), .stall_cnt_o(scnt[0]), .flush_cnt_o(fcnt[0]));

  hazard_unit #(.LOAD_LATENCY(3), .FLUSH_CYCLES(2)) u1 (
    .clk(clk), .reset(reset),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_use_i(rs1_use), .id_rs2_use_i(rs2_use),
    .ex_reg_wr_addr_i(wr_addr), .ex_reg_wr_sig_i(wr_sig), .ex_is_load_i(is_load),
    .ex_br_mispred_i(mispred),
    .pc_stall_o(pc_stall[1]), .if_id_stall_o(ifid_stall[1]), .if_id_flush_o(ifid_flush[1]),
    .id_ex_bubble_o(bubble[1]), .stall_cnt_o(scnt[1]), .flush_cnt_o(fcnt[1]));

  hazard_unit #(.LOAD_LATENCY(4), .FLUSH_CYCLES(3)) u2 (
    .clk(clk), .reset(reset),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_use_i(rs1_use), .id_rs2_use_i(rs2_use),
    .ex_reg_wr_addr_i(wr_addr), .ex_reg_wr_sig_i(wr_sig), .ex_is_load_i(is_load),
    .ex_br_mispred_i(mispred),
    .pc_stall_o(pc_stall[2]), .if_id_stall_o(ifid_stall[2]), .if_id_flush_o(ifid_flush[2]),
    .id_ex_bubble_o(bubble[2]), .stall_cnt_o(scnt[2]), .flush_cnt_o(fcnt[2]));

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  function automatic int get_ll(input int i);
    case (i)
      0: return 1;
      1: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int get_fc(input int i);
    case (i)
      0: return 1;
      1: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining hold cycles per instance plus event tallies.
  int          rem_stall [NI] = '{0, 0, 0};
  int          rem_flush [NI] = '{0, 0, 0};
  logic [31:0] m_scnt [NI] = '{0, 0, 0};
  logic [31:0] m_fcnt [NI] = '{0, 0, 0};

  always @(negedge clk) begin
    logic        lu, es, ef;
    logic [31:0] xs, xf;
    lu = is_load && wr_sig && (wr_addr != 0) &&
         ((rs1_use && rs1 == wr_addr) || (rs2_use && rs2 == wr_addr));
    for (int i = 0; i < NI; i++) begin
      es = 1'b0;
      ef = 1'b0;
      if (!reset) begin
        if (mispred || rem_flush[i] > 0) ef = 1'b1;
        else if (rem_stall[i] > 0 || lu) es = 1'b1;
      end
      xs = (PERF && !reset) ? m_scnt[i] : 32'd0;
      xf = (PERF && !reset) ? m_fcnt[i] : 32'd0;
      chk($sformatf("model_pc_stall[%0d]", i), 32'(pc_stall[i]), 32'(es));
      chk($sformatf("model_if_id_stall[%0d]", i), 32'(ifid_stall[i]), 32'(es));
      chk($sformatf("model_if_id_flush[%0d]", i), 32'(ifid_flush[i]), 32'(ef));
      chk($sformatf("model_bubble[%0d]", i), 32'(bubble[i]), 32'(es | ef));
      chk($sformatf("model_stall_cnt[%0d]", i), scnt[i], xs);
      chk($sformatf("model_flush_cnt[%0d]", i), fcnt[i], xf);
      if (reset) begin
        rem_stall[i] = 0;
        rem_flush[i] = 0;
        m_scnt[i] = 0;
        m_fcnt[i] = 0;
      end else begin
        if (mispred) begin
          rem_flush[i] = get_fc(i) - 1;
          rem_stall[i] = 0;
        end else if (rem_flush[i] > 0) rem_flush[i]--;
        else if (rem_stall[i] > 0) rem_stall[i]--;
        else if (lu) rem_stall[i] = get_ll(i) - 1;
        m_scnt[i] = m_scnt[i] + 32'(es);
        m_fcnt[i] = m_fcnt[i] + 32'(mispred);
      end
    end
  end

  task automatic set_idle();
    rs1 = 5'd0; rs2 = 5'd0; rs1_use = 1'b0; rs2_use = 1'b0;
    wr_addr = 5'd0; wr_sig = 1'b0; is_load = 1'b0; mispred = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] dst, input logic [4:0] a1, input logic u1,
                          input logic [4:0] a2, input logic u2);
    set_idle();
    is_load = 1'b1; wr_sig = 1'b1; wr_addr = dst;
    rs1 = a1; rs1_use = u1; rs2 = a2; rs2_use = u2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      next_cycle();
      set_idle();
    end
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    // Reset masks a live hazard and a mispredict.
    set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    mispred = 1'b1;
    @(negedge clk);
    chk("rst_pc_stall", 32'(pc_stall[1]), 32'd0);
    chk("rst_flush", 32'(ifid_flush[1]), 32'd0);
    chk("rst_bubble", 32'(bubble[2]), 32'd0);
    chk("rst_stall_cnt", scnt[1], 32'd0);
    next_cycle(); reset = 1'b0; set_idle();
    idle_cycles(2);

    // LOAD_LATENCY=3: load x7, ID rs2=x7 -> three stall cycles.
    next_cycle(); set_load(5'd7, 5'd0, 1'b0, 5'd7, 1'b1);
    @(negedge clk);
    chk("ll3_c1_pc_stall", 32'(pc_stall[1]), 32'd1);
    chk("ll1_c1_pc_stall", 32'(pc_stall[0]), 32'd1);
    next_cycle(); set_idle();
    @(negedge clk);
    chk("ll3_c2_if_id_stall", 32'(ifid_stall[1]), 32'd1);
    chk("ll1_c2_pc_stall", 32'(pc_stall[0]), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("ll3_c3_pc_stall", 32'(pc_stall[1]), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("ll3_c4_pc_stall", 32'(pc_stall[1]), 32'd0);
    chk("ll3_stall_cnt", scnt[1], PERF ? 32'd3 : 32'd0);
    idle_cycles(3);

    // x0 and unused-source cases never stall.
    next_cycle(); set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    @(negedge clk);
    chk("x0_no_stall", 32'(bubble[0]), 32'd0);
    next_cycle(); set_load(5'd4, 5'd4, 1'b0, 5'd4, 1'b0);
    @(negedge clk);
    chk("nouse_no_stall", 32'(pc_stall[0]), 32'd0);

    // FLUSH_CYCLES=2 with a concurrent load-use that must be ignored.
    next_cycle(); reset = 1'b1; set_idle();
    next_cycle(); reset = 1'b0;
    next_cycle(); set_load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0); mispred = 1'b1;
    @(negedge clk);
    chk("fc2_c1_flush", 32'(ifid_flush[1]), 32'd1);
    chk("fc2_c1_pc_stall", 32'(pc_stall[1]), 32'd0);
    next_cycle(); mispred = 1'b0;
    @(negedge clk);
    chk("fc2_c2_flush", 32'(ifid_flush[1]), 32'd1);
    chk("fc2_c2_bubble", 32'(bubble[1]), 32'd1);
    chk("fc2_c2_pc_stall", 32'(pc_stall[1]), 32'd0);
    next_cycle(); set_idle();
    @(negedge clk);
    chk("fc2_c3_flush", 32'(ifid_flush[1]), 32'd0);
    chk("fc2_flush_cnt", fcnt[1], PERF ? 32'd1 : 32'd0);
    idle_cycles(3);

    // LOAD_LATENCY=4, mispredict in the 2nd stall cycle (FLUSH_CYCLES=3).
    next_cycle(); set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    chk("ll4_c1_pc_stall", 32'(pc_stall[2]), 32'd1);
    next_cycle(); set_idle(); mispred = 1'b1;
    @(negedge clk);
    chk("ll4_mp_pc_stall", 32'(pc_stall[2]), 32'd0);
    chk("ll4_mp_flush", 32'(ifid_flush[2]), 32'd1);
    next_cycle(); mispred = 1'b0;
    @(negedge clk);
    chk("ll4_f2_flush", 32'(ifid_flush[2]), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("ll4_f3_flush", 32'(ifid_flush[2]), 32'd1);
    chk("ll4_f3_pc_stall", 32'(pc_stall[2]), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("ll4_f4_flush", 32'(ifid_flush[2]), 32'd0);
    chk("ll4_f4_pc_stall", 32'(pc_stall[2]), 32'd0);
    idle_cycles(2);

    // Reset in the 2nd cycle of a 4-cycle stall aborts it.
    next_cycle(); set_load(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
    @(negedge clk);
    chk("rstmid_c1_pc_stall", 32'(pc_stall[2]), 32'd1);
    next_cycle(); reset = 1'b1;
    @(negedge clk);
    chk("rstmid_c2_pc_stall", 32'(pc_stall[2]), 32'd0);
    chk("rstmid_c2_bubble", 32'(bubble[2]), 32'd0);
    next_cycle(); reset = 1'b0; set_idle();
    @(negedge clk);
    chk("rstmid_c3_pc_stall", 32'(pc_stall[2]), 32'd0);
    chk("rstmid_c3_stall_cnt", scnt[2], 32'd0);
    chk("rstmid_c3_flush_cnt", fcnt[2], 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rstmid_c4_bubble", 32'(bubble[2]), 32'd0);

    // Randomised traffic over a small register set to provoke frequent hits.
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      reset   = ($urandom_range(0, 99) == 0);
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      wr_addr = 5'($urandom_range(0, 3));
      rs1_use = 1'($urandom_range(0, 1));
      rs2_use = 1'($urandom_range(0, 1));
      wr_sig  = ($urandom_range(0, 3) != 0);
      is_load = 1'($urandom_range(0, 1));
      mispred = ($urandom_range(0, 7) == 0);
    end
    next_cycle(); set_idle();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
